// File: rtl/coax_pkg.sv
// Shared definitions for the 3270 coax transmitter and receiver:
// TX state encoding, frame field sizes and the frame parity rule.
package coax_pkg;

  localparam int QUIESCE_BITS = 5;
  localparam int DATA_BITS    = 10;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LINE_QUIESCE,
    TX_CODE_VIOLATION,
    TX_SYNC_BIT,
    TX_DATA_BIT,
    TX_PARITY_BIT,
    TX_END_SEQUENCE
  } coax_tx_state_t;

  // Even parity over the sync bit (always 1) and the data word.
  function automatic logic coax_parity(input logic [DATA_BITS-1:0] word);
    return ^{1'b1, word};
  endfunction

endpackage

// File: rtl/coax_tx_bit_timer.sv
// Half-bit timer for the coax transmitter: free-running while a frame is in
// progress, held cleared by the FSM between frames.
module coax_tx_bit_timer #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_strobe,
  output logic bit_strobe,
  output logic second_half
);

  localparam int HALF_CLOCKS = CLOCKS_PER_BIT / 2;
  localparam int CNT_W       = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLOCKS - 1);

  logic [CNT_W-1:0] half_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      half_cnt    <= '0;
      second_half <= 1'b0;
    end else if (half_strobe) begin
      half_cnt    <= '0;
      second_half <= ~second_half;
    end else begin
      half_cnt    <= half_cnt + CNT_W'(1);
    end
  end

  assign half_strobe = (half_cnt == HALF_LAST);
  assign bit_strobe  = half_strobe & second_half;

endmodule

// File: rtl/coax_tx.sv
// 3270 coax frame transmitter: single-entry holding register, framing FSM and
// Manchester line encoder. Optional tx_delay output under COAX_TX_DELAY_EN.
//
// state             | meaning
// TX_IDLE           | line low, waiting for a loaded word
// TX_LINE_QUIESCE   | five 1 cells to wake the receiver
// TX_CODE_VIOLATION | 1.5 cells low then 1.5 cells high
// TX_SYNC_BIT       | sync 1 cell, word moved to the shift register
// TX_DATA_BIT       | ten data cells, MSB first
// TX_PARITY_BIT     | even parity over sync and data
// TX_END_SEQUENCE   | sync 0 cell, then one full cell high
module coax_tx
  import coax_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 load,
  output logic                 ready,
  output logic                 active,
  output logic                 tx
`ifdef COAX_TX_DELAY_EN
  ,
  output logic                 tx_delay
`endif
);

  localparam logic [3:0] QUIESCE_LAST = 4'(QUIESCE_BITS - 1);
  localparam logic [3:0] DATA_LAST    = 4'(DATA_BITS - 1);
  localparam logic [3:0] CV_LAST      = 4'd5;
  localparam logic [3:0] CV_HIGH      = 4'd3;

  coax_tx_state_t state, state_next;

  logic [DATA_BITS-1:0] hold_reg;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic [3:0]           bit_cnt;
  logic                 half_strobe;
  logic                 bit_strobe;
  logic                 second_half;
  logic                 start_word;
  logic                 count_en;
  logic                 cell_val;

  coax_tx_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clk         (clk),
    .reset       (reset),
    .clear       (state == TX_IDLE),
    .half_strobe (half_strobe),
    .bit_strobe  (bit_strobe),
    .second_half (second_half)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= TX_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:
        if (hold_full) state_next = TX_LINE_QUIESCE;
      TX_LINE_QUIESCE:
        if (bit_strobe && bit_cnt == QUIESCE_LAST) state_next = TX_CODE_VIOLATION;
      TX_CODE_VIOLATION:
        if (half_strobe && bit_cnt == CV_LAST) state_next = TX_SYNC_BIT;
      TX_SYNC_BIT:
        if (bit_strobe) state_next = TX_DATA_BIT;
      TX_DATA_BIT:
        if (bit_strobe && bit_cnt == DATA_LAST) state_next = TX_PARITY_BIT;
      TX_PARITY_BIT:
        if (bit_strobe) state_next = hold_full ? TX_SYNC_BIT : TX_END_SEQUENCE;
      TX_END_SEQUENCE:
        if (bit_strobe && bit_cnt == 4'd1) state_next = TX_IDLE;
      default:
        state_next = TX_IDLE;
    endcase
  end

  // The code violation is timed in half cells, every other state in whole cells.
  assign count_en   = (state == TX_CODE_VIOLATION) ? half_strobe : bit_strobe;
  assign start_word = (state_next == TX_SYNC_BIT) && (state != TX_SYNC_BIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      if (state_next != state) bit_cnt <= '0;
      else if (count_en)       bit_cnt <= bit_cnt + 4'd1;

      if (start_word) begin
        shift_reg <= hold_reg;
        par_bit   <= coax_parity(hold_reg);
        hold_full <= 1'b0;
      end else begin
        if (load && !hold_full) begin
          hold_reg  <= data;
          hold_full <= 1'b1;
        end
        if (state == TX_DATA_BIT && bit_strobe)
          shift_reg <= {shift_reg[DATA_BITS-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    cell_val = 1'b1;
    tx       = 1'b0;
    case (state)
      TX_DATA_BIT:   cell_val = shift_reg[DATA_BITS-1];
      TX_PARITY_BIT: cell_val = par_bit;
      default:       cell_val = 1'b1;
    endcase
    case (state)
      TX_IDLE:           tx = 1'b0;
      TX_CODE_VIOLATION: tx = (bit_cnt >= CV_HIGH);
      TX_END_SEQUENCE:   tx = (bit_cnt != 4'd0) | ~second_half;
      default:           tx = second_half ? cell_val : ~cell_val;
    endcase
  end

  assign ready  = ~hold_full;
  assign active = (state != TX_IDLE);

`ifdef COAX_TX_DELAY_EN
  localparam int DLY = CLOCKS_PER_BIT / 4;

  logic [DLY-1:0] dly_q;

  always_ff @(posedge clk) begin
    if (reset || state == TX_IDLE) begin
      dly_q <= '0;
    end else begin
      dly_q[0] <= tx;
      for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign tx_delay = dly_q[DLY-1] & active;
`endif

endmodule

// File: tb/tb_coax_tx.sv
// Self-checking bench for coax_tx: expected line waveform built cell by cell
// from the frame format, compared every clock.
module tb_coax_tx;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] data;
  logic       load;
  logic       ready;
  logic       active;
  logic       tx;
`ifdef COAX_TX_DELAY_EN
  logic       tx_delay;
`endif

  int total = 0;
  int bad   = 0;

  logic [9:0] cur_w[$];
  logic [9:0] nxt_w[$];
  bit         exp_q[$];
  bit         preloaded = 1'b0;

  coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .load     (load),
    .ready    (ready),
    .active   (active),
    .tx       (tx)
`ifdef COAX_TX_DELAY_EN
    ,
    .tx_delay (tx_delay)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_half(input bit v);
    for (int i = 0; i < HALF; i++) exp_q.push_back(v);
  endtask

  task automatic push_cell(input bit v);
    push_half(!v);
    push_half(v);
  endtask

  // Line waveform of one frame carrying cur_w, one entry per clock.
  task automatic build_expected();
    exp_q.delete();
    for (int i = 0; i < 5; i++) push_cell(1'b1);
    for (int i = 0; i < 3; i++) push_half(1'b0);
    for (int i = 0; i < 3; i++) push_half(1'b1);
    foreach (cur_w[j]) begin
      push_cell(1'b1);
      for (int b = 9; b >= 0; b--) push_cell(cur_w[j][b]);
      push_cell(bit'(($countones(cur_w[j]) + 1) % 2));
    end
    push_cell(1'b0);
    push_half(1'b1);
    push_half(1'b1);
  endtask

  task automatic run_frame(input bit chain);
    int n;
    int loaded;
    int chain_at;
    n = cur_w.size();
    build_expected();
    check("frame_len", exp_q.size(), (10 + 12 * n) * CPB);
    if (!preloaded) begin
      check("ready_before_load", ready, 1);
      load = 1'b1;
      data = cur_w[0];
      @(negedge clk);
      load = 1'b0;
    end
    check("ready_after_load", ready, 0);
    check("active_pre", active, 0);
    check("tx_pre", tx, 0);
    loaded   = 1;
    chain_at = (8 + 12 * n) * CPB + $urandom_range(0, 2 * CPB - 1);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      load = 1'b0;
      check($sformatf("tx[%0d]", k), tx, exp_q[k]);
      check($sformatf("active[%0d]", k), active, 1);
`ifdef COAX_TX_DELAY_EN
      check($sformatf("tx_delay[%0d]", k), tx_delay, (k >= 2) ? exp_q[k-2] : 1'b0);
`endif
      if (ready && loaded < n) begin
        load = 1'b1;
        data = cur_w[loaded];
        loaded++;
      end else if (chain && k == chain_at) begin
        load = 1'b1;
        data = nxt_w[0];
      end else if (!ready && ($urandom % 8) == 0) begin
        load = 1'b1;
        data = (($urandom % 2) == 0) ? 10'h0AA : 10'($urandom);
      end
    end
    @(negedge clk);
    load = 1'b0;
    check("tx_end", tx, 0);
    check("active_end", active, 0);
    check("ready_end", ready, !chain);
`ifdef COAX_TX_DELAY_EN
    check("tx_delay_idle", tx_delay, 0);
`endif
    preloaded = chain;
    if (chain) cur_w = nxt_w;
  endtask

  task automatic reset_mid_data();
    int stop_k;
    cur_w.delete();
    cur_w.push_back(10'($urandom));
    build_expected();
    check("rst_ready_before", ready, 1);
    load = 1'b1;
    data = cur_w[0];
    @(negedge clk);
    load = 1'b0;
    stop_k = $urandom_range(9 * CPB, 19 * CPB - 1);
    for (int k = 0; k <= stop_k; k++) begin
      @(negedge clk);
      check($sformatf("rst_tx[%0d]", k), tx, exp_q[k]);
    end
    reset = 1'b1;
    load  = 1'b1;
    data  = 10'h0AA;
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    check("rst_mid_tx", tx, 0);
    check("rst_mid_active", active, 0);
    check("rst_mid_ready", ready, 1);
    repeat (3) @(negedge clk);
    check("rst_mid_stays_idle", active, 0);
    check("rst_mid_tx_idle", tx, 0);
    preloaded = 1'b0;
  endtask

  initial begin
    int n;
    bit chain;
    reset = 1'b1;
    load  = 1'b0;
    data  = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 0);
    check("reset_ready", ready, 1);
    check("reset_active", active, 0);
    load = 1'b1;
    data = 10'h0AA;
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    check("reset_beats_load", ready, 1);
    @(negedge clk);
    check("reset_no_frame", active, 0);

    cur_w = '{10'h155};
    run_frame(1'b0);

    cur_w = '{10'h000, 10'h3FF};
    run_frame(1'b0);

    reset_mid_data();

    cur_w = '{10'h2C3};
    nxt_w = '{10'h11E};
    run_frame(1'b1);
    run_frame(1'b0);

    for (int f = 0; f < 6; f++) begin
      if (!preloaded) begin
        n = $urandom_range(1, 3);
        cur_w.delete();
        for (int i = 0; i < n; i++) cur_w.push_back(10'($urandom));
      end
      chain = (f < 5) && (($urandom % 2) == 1);
      if (chain) begin
        n = $urandom_range(1, 3);
        nxt_w.delete();
        for (int i = 0; i < n; i++) nxt_w.push_back(10'($urandom));
      end
      run_frame(chain);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
